phase_accum: RTL and testbench

PHASE_ACCUM -- requirements
Module: phase_accum

---
 rtl/phase_accum_if.sv | 29 ++
 rtl/phase_accum.sv | 120 ++++++++++++
 tb/tb_phase_accum.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_accum_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : phase_accum_if
// Brief    : Theta sample stream from the phase accumulator to the cordic.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface phase_accum_if #(
    parameter int D_WIDTH = 8
) ();
    logic [D_WIDTH-1:0] theta_out;
    logic               theta_valid;
    logic               theta_ready;
    logic               wrap;

    modport master (
        output theta_out,
        output theta_valid,
        output wrap,
        input  theta_ready
    );

    modport slave (
        input  theta_out,
        input  theta_valid,
        input  wrap,
        output theta_ready
    );
endinterface
`default_nettype wire

// File: rtl/phase_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : phase_accum
// Brief    : NCO phase accumulator with double-buffered FCW, phase offset,
//            phase restart and a valid/ready theta output stage.
// Revision : 1.0
// ---------------------------------------------------------------------------
module phase_accum #(
    parameter int ACC_WIDTH = 16,
    parameter int D_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] fcw_in,
    input  logic                 fcw_load,
    input  logic [D_WIDTH-1:0]   phase_off,
    input  logic                 sync,
    phase_accum_if.master        theta
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OUT   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_fcw_act;
    logic [ACC_WIDTH-1:0] r_fcw_pend;
    logic                 r_pend_flag;
    logic                 r_sync_flag;
    logic [D_WIDTH-1:0]   r_theta;
    logic                 r_wrap;

    logic                 w_valid;
    logic                 w_advance;
    logic [ACC_WIDTH-1:0] w_acc_base;
    logic [ACC_WIDTH:0]   w_acc_sum;
    logic [D_WIDTH-1:0]   w_theta_next;

    assign w_valid   = (r_state != S_IDLE);
    assign w_advance = en && (!w_valid || theta.theta_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_advance) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT, S_STALL: begin
                if (w_advance) begin
                    w_state_next = S_OUT;
                end else if (theta.theta_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_STALL;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A restart (latched or same-cycle) emits theta from a zero accumulator.
    always_comb begin
        w_acc_base   = (r_sync_flag || sync) ? '0 : r_acc;
        w_acc_sum    = {1'b0, w_acc_base} + {1'b0, r_fcw_act};
        w_theta_next = w_acc_base[ACC_WIDTH-1 -: D_WIDTH] + phase_off;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_fcw_act   <= '0;
            r_fcw_pend  <= '0;
            r_pend_flag <= 1'b0;
            r_sync_flag <= 1'b0;
            r_theta     <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_advance) begin
                r_theta     <= w_theta_next;
                r_acc       <= w_acc_sum[ACC_WIDTH-1:0];
                r_wrap      <= w_acc_sum[ACC_WIDTH];
                r_sync_flag <= 1'b0;
                if (r_pend_flag) begin
                    r_fcw_act   <= r_fcw_pend;
                    r_pend_flag <= 1'b0;
                end
            end else if (sync) begin
                r_sync_flag <= 1'b1;
            end
            // A word captured here waits for the next advance to take effect.
            if (fcw_load) begin
                r_fcw_pend  <= fcw_in;
                r_pend_flag <= 1'b1;
            end
        end
    end

    assign theta.theta_out   = r_theta;
    assign theta.theta_valid = w_valid;
    assign theta.wrap        = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_phase_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_phase_accum
// Brief    : Scoreboard bench for phase_accum (ACC_WIDTH=16, D_WIDTH=8).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_phase_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] fcw_in;
    logic        fcw_load;
    logic [7:0]  phase_off;
    logic        sync;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] theta;
        logic       wrap;
    } exp_t;

    exp_t sb[$];

    phase_accum_if #(.D_WIDTH(8)) th ();

    phase_accum #(
        .ACC_WIDTH(16),
        .D_WIDTH  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .fcw_in   (fcw_in),
        .fcw_load (fcw_load),
        .phase_off(phase_off),
        .sync     (sync),
        .theta    (th)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] t, input logic w);
        exp_t e;
        e.theta = t;
        e.wrap  = w;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; fcw_in = '0; fcw_load = 1'b0;
        phase_off = 8'h00; sync = 1'b0; th.theta_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (th.theta_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", th.theta_valid);
        end
        checks++;
        if (th.theta_out !== 8'h00) begin
            failures++; $display("FAIL reset_theta got=%0d want=0", th.theta_out);
        end
        checks++;
        if (th.wrap !== 1'b0) begin
            failures++; $display("FAIL reset_wrap got=%b want=0", th.wrap);
        end
    endtask

    task automatic test_ramp();
        exp_t e;
        rst = 1'b0; fcw_in = 16'h1000; fcw_load = 1'b1;
        tick();
        checks++;
        if (th.theta_valid !== 1'b0) begin
            failures++; $display("FAIL ramp_idle valid got=%b want=0", th.theta_valid);
        end
        fcw_load = 1'b0; en = 1'b1;
        // The first advance still runs on the reset word and commits 0x1000.
        push(8'd0, 1'b0);
        push(8'd0, 1'b0);
        for (int k = 1; k <= 15; k++) push(8'(k * 16), (k == 15));
        push(8'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL ramp_empty step=%0d", i);
            end else begin
                e = sb.pop_front();
                if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta || th.wrap !== e.wrap) begin
                    failures++;
                    $display("FAIL ramp step=%0d got theta=%0d valid=%b wrap=%b want theta=%0d valid=1 wrap=%b",
                             i, th.theta_out, th.theta_valid, th.wrap, e.theta, e.wrap);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        push(8'd16, 1'b0); push(8'd32, 1'b0); push(8'd48, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            e = sb.pop_front();
            if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta || th.wrap !== e.wrap) begin
                failures++;
                $display("FAIL stall_lead step=%0d got theta=%0d valid=%b want theta=%0d valid=1",
                         i, th.theta_out, th.theta_valid, e.theta);
            end
        end
        th.theta_ready = 1'b0; phase_off = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (th.theta_valid !== 1'b1 || th.theta_out !== 8'd48 || th.wrap !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got theta=%0d valid=%b wrap=%b want theta=48 valid=1 wrap=0",
                         i, th.theta_out, th.theta_valid, th.wrap);
            end
        end
        th.theta_ready = 1'b1; phase_off = 8'h00;
        push(8'd64, 1'b0);
        tick();
        checks++;
        e = sb.pop_front();
        if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta) begin
            failures++; $display("FAIL stall_release got theta=%0d valid=%b want theta=%0d valid=1",
                                 th.theta_out, th.theta_valid, e.theta);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (th.theta_valid !== 1'b0 || th.theta_out !== 8'd64) begin
                failures++; $display("FAIL en_low cycle=%0d got theta=%0d valid=%b want theta=64 valid=0",
                                     i, th.theta_out, th.theta_valid);
            end
        end
        en = 1'b1;
        push(8'd80, 1'b0);
        tick();
        checks++;
        e = sb.pop_front();
        if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta) begin
            failures++; $display("FAIL en_resume got theta=%0d want theta=%0d", th.theta_out, e.theta);
        end
    endtask

    task automatic test_fcw_change();
        exp_t e;
        sync = 1'b1;
        push(8'd0, 1'b0);
        tick();
        checks++;
        e = sb.pop_front();
        if (th.theta_out !== e.theta || th.theta_valid !== 1'b1) begin
            failures++; $display("FAIL fcw_restart got theta=%0d want theta=%0d", th.theta_out, e.theta);
        end
        sync = 1'b0; fcw_load = 1'b1; fcw_in = 16'h2000;
        push(8'd16, 1'b0);
        tick();
        fcw_load = 1'b0;
        push(8'd32, 1'b0); push(8'd48, 1'b0); push(8'd80, 1'b0); push(8'd112, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            e = sb.pop_front();
            if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta || th.wrap !== e.wrap) begin
                failures++; $display("FAIL fcw_change step=%0d got theta=%0d want theta=%0d",
                                     i, th.theta_out, e.theta);
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        en = 1'b0; fcw_load = 1'b1; fcw_in = 16'h1000;
        tick();
        fcw_load = 1'b0; en = 1'b1; sync = 1'b1;
        push(8'd0, 1'b0);
        tick();
        sync = 1'b0;
        push(8'd32, 1'b0); push(8'd48, 1'b0); push(8'd64, 1'b0); push(8'd80, 1'b0); push(8'd96, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            e = sb.pop_front();
            if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta) begin
                failures++; $display("FAIL sync_lead step=%0d got theta=%0d want theta=%0d",
                                     i, th.theta_out, e.theta);
            end
        end
        sync = 1'b1; phase_off = 8'h10;
        push(8'h10, 1'b0);
        tick();
        sync = 1'b0;
        push(8'h20, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            checks++;
            e = sb.pop_front();
            if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta) begin
                failures++; $display("FAIL sync_now step=%0d got theta=%0h want theta=%0h",
                                     i, th.theta_out, e.theta);
            end
        end
        en = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        en = 1'b1;
        push(8'h10, 1'b0);
        tick();
        push(8'h20, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            checks++;
            e = sb.pop_front();
            if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta) begin
                failures++; $display("FAIL sync_latched step=%0d got theta=%0h want theta=%0h",
                                     i, th.theta_out, e.theta);
            end
        end
    endtask

    task automatic test_reset_stall();
        exp_t e;
        th.theta_ready = 1'b0;
        tick();
        checks++;
        if (th.theta_valid !== 1'b1 || th.theta_out !== 8'h20) begin
            failures++; $display("FAIL rst_prestall got theta=%0h valid=%b want theta=20 valid=1",
                                 th.theta_out, th.theta_valid);
        end
        rst = 1'b1; fcw_load = 1'b1; fcw_in = 16'hABCD; sync = 1'b1;
        tick();
        checks++;
        if (th.theta_valid !== 1'b0) begin
            failures++; $display("FAIL rst_stall_valid got=%b want=0", th.theta_valid);
        end
        checks++;
        if (th.theta_out !== 8'h00) begin
            failures++; $display("FAIL rst_stall_theta got=%0h want=0", th.theta_out);
        end
        checks++;
        if (th.wrap !== 1'b0) begin
            failures++; $display("FAIL rst_stall_wrap got=%b want=0", th.wrap);
        end
        rst = 1'b0; fcw_load = 1'b0; sync = 1'b0; phase_off = 8'h37; th.theta_ready = 1'b1;
        // The word loaded under reset must be discarded, so the phase stays put.
        push(8'h37, 1'b0); push(8'h37, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            e = sb.pop_front();
            if (th.theta_valid !== 1'b1 || th.theta_out !== e.theta || th.wrap !== e.wrap) begin
                failures++; $display("FAIL post_reset step=%0d got theta=%0h valid=%b want theta=%0h valid=1",
                                     i, th.theta_out, th.theta_valid, e.theta);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        th.theta_ready = 1'b1;
        test_reset();
        test_ramp();
        test_stall();
        test_fcw_change();
        test_sync();
        test_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
